lamp_scan_scheduler: RTL
========================

Name: lamp_scan_scheduler

Overview:
Sequencer for the four-channel counter/lamp datapath. Generates single-cycle count-enable strobes for the four channel counters from one free-running prescaler, so no derived clocks are needed. Selects which channel drives the 8 lamps, either from a manual selector or by auto-scanning channels 0..3 with a programmable dwell. Sits between the 10 MHz clock domain output and the lamp pins; the counters themselves are external.

Parameters:
DATA_W, 8, width of each channel value and of lamps
TAP0, 10, prescaler bit for tick[0]; strobe period 2^(TAP0+1) cycles
TAP1, 15, prescaler bit for tick[1]
TAP2, 20, prescaler bit for tick[2]
TAP3, 25, prescaler bit for tick[3]; prescaler width = TAP3+1; TAP0<TAP1<TAP2<TAP3 required
DWELL, 10000000, auto-scan cycles per channel (1 s at 10 MHz), >=2
BLANK, 1000, blank-gap cycles between channels (used only with SCAN_BLANK_EN), >=1

Ports:
clk  in  1  10 MHz system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  0 forces lamps dark and returns FSM to IDLE
auto_mode  in  1  1 = auto-scan, 0 = manual select
s  in  2  manual channel select
hold  in  1  auto mode: freeze on the current channel; dwell counter paused
ch_data  in  4*DATA_W  channel values; channel k at bits [k*DATA_W +: DATA_W]
tick  out  4  one-cycle count-enable strobes to channel counters
ch_sel  out  2  channel currently driving lamps
lamps  out  DATA_W  registered lamp drive
scan_wrap  out  1  one-cycle pulse when auto-scan advances 3->0

Behaviour:
- Reset (async assert, synchronous release): prescaler=0, tick=0, ch_sel=0, lamps=0, scan_wrap=0, dwell counter=0, state=IDLE.
- Prescaler: increments every clk regardless of enable; wraps at 2^(TAP3+1)-1 -> 0.
- tick[k] is high for exactly the cycle after prescaler[TAPk:0] is all ones, i.e. registered with 1-cycle latency. First tick[0] appears in cycle 2^(TAP0+1) after reset release. At the prescaler wrap, all four ticks fire in the same cycle.
- States: IDLE, MANUAL, SCAN, BLANK.
- IDLE: lamps=0. enable=1 -> MANUAL if auto_mode=0, else SCAN with dwell=0.
- MANUAL: ch_sel<=s each cycle; lamps<=ch_data[ch_sel] (lamps lag s by 2 cycles). auto_mode=1 -> SCAN, starting at current ch_sel, dwell=0.
- SCAN: lamps<=ch_data[ch_sel]. Dwell increments each cycle unless hold=1. When dwell==DWELL-1 and hold=0: dwell<=0 and ch_sel<=ch_sel+1 (mod 4), or go to BLANK (see Optional Feature). scan_wrap pulses in the cycle ch_sel changes 3->0. auto_mode=0 -> MANUAL.
- enable=0 in any state -> IDLE next cycle; lamps=0 from that edge. ch_sel keeps its value.
- hold is ignored in MANUAL and IDLE.
- Simultaneous dwell expiry and auto_mode drop: the mode change wins; ch_sel does not advance.
- ch_data changing mid-dwell is reflected on lamps 1 cycle later. The value is not latched.
- Reset asserted mid-scan: all outputs return to reset values immediately.

Optional Feature:
SCAN_BLANK_EN
- Defined: dwell expiry in SCAN -> BLANK. lamps=0 for BLANK cycles, then ch_sel advances and the FSM returns to SCAN. scan_wrap pulses on the 3->0 advance at BLANK exit. hold=1 in BLANK freezes the blank counter. auto_mode=0 in BLANK -> MANUAL.
- Not defined: no BLANK state; ch_sel advances directly on dwell expiry.

Test Plan:
- Reset release, TAP0=2, TAP3=5: tick[0] every 8 cycles, first at cycle 8; tick[3] every 64 cycles; all ticks coincide every 64 cycles.
- enable=1, auto_mode=0, ch_data={8'h44,8'h33,8'h22,8'h11}, s=2: lamps=8'h33 two cycles later; s=0 -> lamps=8'h11.
- auto_mode=1, DWELL=4: ch_sel sequence 0,0,0,0,1,1,1,1,2...; scan_wrap pulses once per 16 cycles on the 3->0 step.
- In SCAN, hold=1 for 10 cycles during the dwell on channel 1: ch_sel stays at 1 for 14 cycles total; no scan_wrap.
- enable dropped mid-scan: lamps=0 next cycle. enable re-raised: scan resumes at the same ch_sel with dwell=0.
- SCAN_BLANK_EN, DWELL=4, BLANK=2: lamps show 4 cycles of data, then 2 cycles of 0, then the next channel; rst_n pulsed during BLANK -> lamps=0, ch_sel=0 asynchronously.

Source files
------------

// File: rtl/lamp_scan_scheduler.sv
// Count-enable strobe generator and lamp channel sequencer (manual select or auto-scan).
// Optional blank gap between auto-scanned channels: define SCAN_BLANK_EN.
module lamp_scan_scheduler #(
  parameter int DATA_W = 8,
  parameter int TAP0   = 10,
  parameter int TAP1   = 15,
  parameter int TAP2   = 20,
  parameter int TAP3   = 25,
  parameter int DWELL  = 10000000,
  parameter int BLANK  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  auto_mode,
  input  logic [1:0]            s,
  input  logic                  hold,
  input  logic [4*DATA_W-1:0]   ch_data,
  output logic [3:0]            tick,
  output logic [1:0]            ch_sel,
  output logic [DATA_W-1:0]     lamps,
  output logic                  scan_wrap
);

  localparam int PS_W    = TAP3 + 1;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_MANUAL, ST_SCAN, ST_BLANK} state_t;

  state_t            state;
  logic [PS_W-1:0]   prescaler;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sel_data;

  // A strobe fires the cycle after the low TAPk+1 prescaler bits are all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      tick      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prescaler <= prescaler + PS_W'(1);
      tick      <= {&prescaler[TAP3:0], &prescaler[TAP2:0],
                    &prescaler[TAP1:0], &prescaler[TAP0:0]};
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves sel_data unassigned (no latch).
    sel_data = ch_data[0 +: DATA_W];
    case (ch_sel)
      2'd1:    sel_data = ch_data[DATA_W   +: DATA_W];
      2'd2:    sel_data = ch_data[2*DATA_W +: DATA_W];
      2'd3:    sel_data = ch_data[3*DATA_W +: DATA_W];
      default: sel_data = ch_data[0 +: DATA_W];
    endcase
  end

  // cnt is the dwell counter in SCAN and the gap counter in BLANK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch_sel    <= 2'd0;
      lamps     <= '0;
      scan_wrap <= 1'b0;
      cnt       <= '0;
    end else begin
      scan_wrap <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        lamps <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            lamps <= '0;
            cnt   <= '0;
            state <= auto_mode ? ST_SCAN : ST_MANUAL;
          end
          ST_MANUAL: begin
            lamps <= sel_data;
            if (auto_mode) begin
              state <= ST_SCAN;
              cnt   <= '0;
            end else begin
              ch_sel <= s;
            end
          end
          ST_SCAN: begin
            lamps <= sel_data;
            if (!auto_mode) begin
              state <= ST_MANUAL;
            end else if (!hold) begin
              if (cnt == DWELL_LAST) begin
                cnt <= '0;
`ifdef SCAN_BLANK_EN
                state <= ST_BLANK;
`else
                ch_sel    <= ch_sel + 2'd1;
                scan_wrap <= (ch_sel == 2'd3);
`endif
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
`ifdef SCAN_BLANK_EN
          ST_BLANK: begin
            lamps <= '0;
            if (!auto_mode) begin
              state <= ST_MANUAL;
            end else if (!hold) begin
              if (cnt == BLANK_LAST) begin
                cnt       <= '0;
                state     <= ST_SCAN;
                ch_sel    <= ch_sel + 2'd1;
                scan_wrap <= (ch_sel == 2'd3);
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
`endif
          default: begin
            state <= ST_IDLE;
            lamps <= '0;
          end
        endcase
      end
    end
  end

endmodule
